// File: rtl/led_pattern_gen.sv
// Mode-selectable LED pattern generator (blink/count/chase/ping-pong) stepped by a programmable prescaler.
// tick and leds are registered together; `define LED_PWM_EN adds brightness gating with one extra cycle on leds.
module led_pattern_gen #(
   parameter int N_LEDS      = 8,
   parameter int DIV_W       = 26,
   parameter int DEFAULT_DIV = 25000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic              div_load,
   input  logic [DIV_W-1:0]  div_value,
`ifdef LED_PWM_EN
   input  logic [3:0]        brightness,
`endif
   output logic              tick,
   output logic [N_LEDS-1:0] leds
);

   localparam logic [1:0] MODE_BLINK = 2'b00;
   localparam logic [1:0] MODE_COUNT = 2'b01;
   localparam logic [1:0] MODE_CHASE = 2'b10;
   localparam logic [1:0] MODE_PING  = 2'b11;
   localparam logic       DIR_LEFT   = 1'b0;
   localparam logic       DIR_RIGHT  = 1'b1;

   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              tick_q, tick_d;
   logic [N_LEDS-1:0] pat_q, pat_d;
   logic [1:0]        mode_q, mode_d;
   logic              dir_q, dir_d;

   logic [N_LEDS-1:0] nxt_pat;
   logic              nxt_dir;
   logic [N_LEDS-1:0] seed_pat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         div_q  <= DIV_W'(DEFAULT_DIV);
         tick_q <= 1'b0;
         pat_q  <= '0;
         mode_q <= MODE_BLINK;
         dir_q  <= DIR_LEFT;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         tick_q <= tick_d;
         pat_q  <= pat_d;
         mode_q <= mode_d;
         dir_q  <= dir_d;
      end
   end

   // Pattern advance within the current mode; a single LED cannot move, so ping-pong holds.
   always_comb begin
      nxt_pat = pat_q;
      nxt_dir = dir_q;
      case (mode_q)
         MODE_BLINK: nxt_pat = ~pat_q;
         MODE_COUNT: nxt_pat = pat_q + N_LEDS'(1);
         MODE_CHASE: nxt_pat = (pat_q << 1) | (pat_q >> (N_LEDS - 1));
         MODE_PING: begin
            if (N_LEDS > 1) begin
               if (dir_q == DIR_LEFT) begin
                  if (pat_q[N_LEDS-1]) begin
                     nxt_dir = DIR_RIGHT;
                     nxt_pat = pat_q >> 1;
                  end else begin
                     nxt_pat = pat_q << 1;
                  end
               end else begin
                  if (pat_q[0]) begin
                     nxt_dir = DIR_LEFT;
                     nxt_pat = pat_q << 1;
                  end else begin
                     nxt_pat = pat_q >> 1;
                  end
               end
            end
         end
         default: nxt_pat = pat_q;
      endcase
   end

   always_comb begin
      seed_pat = N_LEDS'(1);
      case (mode)
         MODE_BLINK: seed_pat = '1;
         MODE_COUNT: seed_pat = '0;
         default:    seed_pat = N_LEDS'(1);
      endcase
   end

   // A divisor load outranks everything and restarts the step period from zero.
   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      tick_d = 1'b0;
      pat_d  = pat_q;
      mode_d = mode_q;
      dir_d  = dir_q;
      if (div_load) begin
         div_d = (div_value == '0) ? DIV_W'(1) : div_value;
         cnt_d = '0;
      end else if (enable) begin
         if (cnt_q == div_q - DIV_W'(1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (mode != mode_q) begin
               mode_d = mode;
               pat_d  = seed_pat;
               dir_d  = DIR_LEFT;
            end else begin
               pat_d = nxt_pat;
               dir_d = nxt_dir;
            end
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end
   end

   assign tick = tick_q;

`ifdef LED_PWM_EN
   logic [3:0]        pwm_q;
   logic [N_LEDS-1:0] leds_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_q  <= 4'd0;
         leds_q <= '0;
      end else begin
         pwm_q  <= pwm_q + 4'd1;
         leds_q <= pat_q & {N_LEDS{pwm_q < brightness}};
      end
   end

   assign leds = leds_q;
`else
   assign leds = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen (N_LEDS=4, DEFAULT_DIV=4): expected tick values and spacing are queued and matched per tick.
module tb_led_pattern_gen;

   localparam int N     = 4;
   localparam int DIV_W = 8;

   logic             clk;
   logic             rst;
   logic             enable;
   logic [1:0]       mode;
   logic             div_load;
   logic [DIV_W-1:0] div_value;
   logic             tick;
   logic [N-1:0]     leds;

   typedef struct {
      logic [N-1:0] leds;
      int           gap;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   edge_cnt = 0;

   led_pattern_gen #(.N_LEDS(N), .DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .mode(mode),
      .div_load(div_load),
      .div_value(div_value),
      .tick(tick),
      .leds(leds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic push(input logic [N-1:0] l, input int gap);
      exp_t e;
      e.leds = l;
      e.gap  = gap;
      sb.push_back(e);
   endtask

   // Inputs only change just after a falling edge, so the monitor sees what the last rising edge saw.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) step();
      check_eq("drain", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         edge_cnt = 0;
      end else begin
         if (enable) edge_cnt++;
         if (tick) begin
            if (sb.size() == 0) begin
               check_eq("spurious_tick", {31'd0, tick}, 32'd0);
            end else begin
               e = sb.pop_front();
               check_eq("tick_leds", leds, e.leds);
               check_eq("tick_gap", edge_cnt, e.gap);
            end
            edge_cnt = 0;
         end
      end
   end

   initial begin
      rst       = 1'b0;
      enable    = 1'b0;
      mode      = 2'b10;
      div_load  = 1'b0;
      div_value = '0;
      #2 rst = 1'b1;
      #1;
      check_eq("rst_leds", leds, 4'b0000);
      check_eq("rst_tick", tick, 1'b0);
      step();
      step();

      // Chase from reset: first step reseeds, then rotates and wraps.
      push(4'b0001, 4); push(4'b0010, 4); push(4'b0100, 4); push(4'b1000, 4); push(4'b0001, 4);
      rst    = 1'b0;
      enable = 1'b1;
      wait_drain(40);
      enable = 1'b0;

      for (int i = 0; i < 10; i++) begin
         step();
         check_eq("freeze_leds", leds, 4'b0001);
      end
      check_eq("freeze_tick", tick, 1'b0);

      // Ping-pong: each end value appears once.
      mode = 2'b11;
      push(4'b0001, 4); push(4'b0010, 4); push(4'b0100, 4); push(4'b1000, 4);
      push(4'b0100, 4); push(4'b0010, 4); push(4'b0001, 4); push(4'b0010, 4);
      enable = 1'b1;
      wait_drain(60);
      enable = 1'b0;

      // Mid-run asynchronous reset, then restart.
      mode = 2'b10;
      push(4'b0001, 4);
      enable = 1'b1;
      wait_drain(20);
      step();
      step();
      rst = 1'b1;
      #1;
      check_eq("midrst_leds", leds, 4'b0000);
      check_eq("midrst_tick", tick, 1'b0);
      step();
      step();
      push(4'b0001, 4);
      rst = 1'b0;
      wait_drain(20);
      enable = 1'b0;

      // Binary count through a full wrap.
      mode = 2'b01;
      for (int v = 0; v < 16; v++) push(N'(v), 4);
      push(4'b0000, 4);
      enable = 1'b1;
      wait_drain(100);
      enable = 1'b0;

      mode = 2'b00;
      push(4'b1111, 4); push(4'b0000, 4); push(4'b1111, 4);
      enable = 1'b1;
      wait_drain(30);
      enable = 1'b0;

      // Divisor 0 behaves as 1; load honoured while disabled.
      div_load  = 1'b1;
      div_value = 8'd0;
      step();
      div_load = 1'b0;
      push(4'b0000, 1); push(4'b1111, 1); push(4'b0000, 1); push(4'b1111, 1);
      enable = 1'b1;
      wait_drain(20);
      enable = 1'b0;

      div_load  = 1'b1;
      div_value = 8'd2;
      step();
      div_load = 1'b0;
      push(4'b0000, 2); push(4'b1111, 2); push(4'b0000, 2);
      enable = 1'b1;
      wait_drain(20);
      enable = 1'b0;

      // Load landing on the terminal count suppresses that tick and restarts the count.
      div_load  = 1'b1;
      div_value = 8'd4;
      step();
      div_load = 1'b0;
      push(4'b1111, 4);
      enable = 1'b1;
      for (int i = 0; i < 20 && !tick; i++) step();
      check_eq("tc_sync", tick, 1'b1);
      push(4'b0000, 6);
      step();
      step();
      step();
      div_load  = 1'b1;
      div_value = 8'd2;
      step();
      div_load = 1'b0;
      push(4'b1111, 2);
      wait_drain(20);
      enable = 1'b0;
      step();
      step();

      check_eq("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED driver that generates blink, binary-count, chase and ping-pong patterns on N_LEDS outputs. A programmable prescaler derives the pattern step rate from the system clock. The block connects directly to the board LED bank, with clk tied to the board oscillator. It replaces the fixed 2-LED blinker with a configurable, mode-selectable generator.

Parameters:
N_LEDS, 8, number of LED outputs (>=1)
DIV_W, 26, prescaler counter and divisor width
DEFAULT_DIV, 25000000, divisor value loaded at reset (>=1, fits DIV_W)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
enable  input  1  1 = prescaler runs; 0 = freeze counter, pattern and tick
mode  input  2  00 blink, 01 binary count, 10 chase, 11 ping-pong
div_load  input  1  single-cycle strobe: load div_value into divisor register
div_value  input  DIV_W  new divisor; 0 is treated as 1
tick  output  1  registered, one-cycle pulse on each pattern step
leds  output  N_LEDS  registered LED pattern, 1 = LED on

Behaviour:
- Reset (asynchronous, takes effect immediately without a clock edge): leds=0, tick=0, prescaler count=0, div_q=DEFAULT_DIV, mode_q=00, direction=left.
- Prescaler: on each edge with enable=1, count increments. When count==div_q-1: count<=0, tick<=1, pattern steps. Otherwise tick<=0.
- Step period is div_q cycles. The first tick after reset release occurs on the div_q-th enabled edge.
- enable=0: count, leds, direction and mode_q hold; tick<=0.
- div_load=1, highest priority: div_q<=(div_value==0 ? 1 : div_value); count<=0; tick<=0 that cycle; pattern unchanged. The load is honoured even when enable=0.
- div_q=1: tick is asserted on every enabled cycle.
- mode is sampled only on tick edges.
  - If mode!=mode_q: mode_q<=mode, leds<=seed(mode), direction<=left.
  - Seeds: blink all-ones; count 0; chase and ping-pong one-hot bit0.
  - Else leds<=next(mode_q).
- next():
  - Blink: leds<=~leds.
  - Count: leds<=leds+1, modulo 2^N_LEDS; wraps all-ones -> 0.
  - Chase: rotate left by 1; bit N-1 wraps to bit0.
  - Ping-pong, direction left: if leds[N-1] then direction<=right and shift right, else shift left.
  - Ping-pong, direction right: if leds[0] then direction<=left and shift left, else shift right.
  - N_LEDS=1: chase and ping-pong hold at 1.
- Non-one-hot value in chase or ping-pong (only reachable after a mode change, which reseeds): not reachable; no recovery logic is needed.
- tick and leds update on the same edge.
- Reset asserted mid-pattern: all state returns to reset values. After release, the first step reseeds from the current mode because mode_q=00; if mode=00, the first step inverts 0 to all-ones.

Optional Feature:
LED_PWM_EN
- Defined:
  - Adds input brightness[3:0] and a free-running 4-bit pwm counter (reset 0, increments every clk regardless of enable).
  - Output leds = pattern_q AND replicate(pwm_cnt < brightness).
  - brightness=0 keeps all LEDs dark; brightness=15 gives 15/16 duty.
  - tick behaviour is unchanged.
  - The output stays registered: the gated value is registered, adding 1 cycle of latency to leds relative to tick.
- Undefined: no brightness port, no pwm counter; leds = pattern register directly.

Test Plan:
- Bench parameters for all scenarios: N_LEDS=4, DEFAULT_DIV=4.
- Reset: assert rst asynchronously between edges mid-run -> leds=0000 and tick=0 immediately; after release with mode=10, enable=1 -> first tick at the 4th edge, leds=0001.
- Chase: mode=10, enable=1 -> tick every 4 cycles, leds 0001,0010,0100,1000,0001 (wrap); hold enable=0 for 10 cycles -> leds frozen, no tick.
- Ping-pong: mode=11 -> leds 0001,0010,0100,1000,0100,0010,0001,0010; each end value is shown once.
- Count and blink:
  - mode=01 for 17 ticks -> leds 0000,0001,...,1111,0000.
  - Switch to mode=00 -> next tick 1111, then 0000, then 1111.
- Divisor:
  - div_load with div_value=0 -> tick every cycle.
  - div_value=2 -> tick every 2nd cycle.
  - div_load coinciding with the terminal count -> no tick that cycle, count restarts at 0.
- LED_PWM_EN: chase leds=0001, brightness=4 -> leds[0] high exactly 4 of every 16 cycles; brightness=0 -> leds=0000 constantly.
